// File: rtl/lf_multiword_add_seq.sv
// Operand sequencer for an external 8-bit adder: feeds wide operands one byte
// per cycle LSB first, chains the byte carry and returns the assembled sum.
module lf_multiword_add_seq #(
    parameter int NUM_BYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8*NUM_BYTES-1:0] in_a,
    input  logic [8*NUM_BYTES-1:0] in_b,
    input  logic                   in_cin,
    output logic [7:0]             add_num1,
    output logic [7:0]             add_num2,
    output logic                   add_carry_in,
    input  logic [8:0]             add_sum,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*NUM_BYTES-1:0] out_sum,
    output logic                   out_cout
);
    localparam int W  = 8 * NUM_BYTES;
    localparam int IW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  sum_reg;
    logic          carry;
    logic          cout_reg;
    logic [IW-1:0] idx;
    logic          last;

    assign last     = (idx == LAST);
    assign out_sum  = sum_reg;
    assign out_cout = cout_reg;

    always_comb begin
        state_nx     = state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        add_num1     = '0;
        add_num2     = '0;
        add_carry_in = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid && !rst) state_nx = RUN;
            end
            RUN: begin
                add_carry_in = carry;
                // Byte select by compare loop keeps every slice index constant.
                for (int unsigned i = 0; i < NUM_BYTES; i++) begin
                    if (idx == IW'(i)) begin
                        add_num1 = a_reg[8*i +: 8];
                        add_num2 = b_reg[8*i +: 8];
                    end
                end
                if (last) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            sum_reg  <= '0;
            carry    <= 1'b0;
            cout_reg <= 1'b0;
            idx      <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= in_a;
                        b_reg <= in_b;
                        carry <= in_cin;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    for (int unsigned i = 0; i < NUM_BYTES; i++) begin
                        if (idx == IW'(i)) sum_reg[8*i +: 8] <= add_sum[7:0];
                    end
                    carry <= add_sum[8];
                    if (last) begin
                        idx      <= '0;
                        cout_reg <= add_sum[8];
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lf_multiword_add_seq.sv
// Directed bench for lf_multiword_add_seq: 4-byte and 1-byte instances, each
// driving a behavioural 8-bit adder.
module tb_lf_multiword_add_seq;
    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // 4-byte instance
    logic        iv4, ir4, cin4, ci4, ov4, or4, oc4;
    logic [31:0] a4, b4, os4;
    logic [7:0]  n1_4, n2_4;
    logic [8:0]  s4;
    assign s4 = {1'b0, n1_4} + {1'b0, n2_4} + {8'd0, ci4};

    lf_multiword_add_seq #(.NUM_BYTES(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4),
        .in_a(a4), .in_b(b4), .in_cin(cin4),
        .add_num1(n1_4), .add_num2(n2_4), .add_carry_in(ci4), .add_sum(s4),
        .out_valid(ov4), .out_ready(or4), .out_sum(os4), .out_cout(oc4)
    );

    // 1-byte instance
    logic       iv1, ir1, cin1, ci1, ov1, or1, oc1;
    logic [7:0] a1, b1, os1, n1_1, n2_1;
    logic [8:0] s1;
    assign s1 = {1'b0, n1_1} + {1'b0, n2_1} + {8'd0, ci1};

    lf_multiword_add_seq #(.NUM_BYTES(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
        .in_a(a1), .in_b(b1), .in_cin(cin1),
        .add_num1(n1_1), .add_num2(n2_1), .add_carry_in(ci1), .add_sum(s1),
        .out_valid(ov1), .out_ready(or1), .out_sum(os1), .out_cout(oc1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [31:0] ta [8];
    logic [31:0] tb [8];
    logic        tc [8];
    logic [32:0] ref_sum;
    int          last_cyc;
    int          waited;

    initial begin
        rst = 1'b1;
        iv4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; or4 = 1'b0;
        iv1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; or1 = 1'b0;
        ta[0] = 32'hDEADBEEF; tb[0] = 32'h21524110; tc[0] = 1'b1;
        ta[1] = 32'h80000000; tb[1] = 32'h80000000; tc[1] = 1'b0;
        ta[2] = 32'h00FF00FF; tb[2] = 32'h00010001; tc[2] = 1'b0;
        ta[3] = 32'h12345678; tb[3] = 32'h87654321; tc[3] = 1'b1;
        ta[4] = 32'hFFFFFFFF; tb[4] = 32'hFFFFFFFF; tc[4] = 1'b1;
        ta[5] = 32'h00000000; tb[5] = 32'h00000000; tc[5] = 1'b0;
        ta[6] = 32'hCAFEF00D; tb[6] = 32'h0BADC0DE; tc[6] = 1'b0;
        ta[7] = 32'h7FFFFFFF; tb[7] = 32'h00000000; tc[7] = 1'b1;

        // Reset state
        step();
        step();
        chk("rst_in_ready_forced", 64'(ir4), 64'd0);
        chk("rst_out_valid", 64'(ov4), 64'd0);
        chk("rst_out_sum", 64'(os4), 64'd0);
        chk("rst_out_cout", 64'(oc4), 64'd0);
        chk("rst_add_num1", 64'(n1_4), 64'd0);
        chk("rst_add_carry", 64'(ci4), 64'd0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready4", 64'(ir4), 64'd1);
        chk("idle_in_ready1", 64'(ir1), 64'd1);

        // 1-byte: 0x58 + 0xBB = 0x113
        a1 = 8'h58; b1 = 8'hBB; cin1 = 1'b0; iv1 = 1'b1; or1 = 1'b1;
        step();
        iv1 = 1'b0;
        chk("nb1_run_valid", 64'(ov1), 64'd0);
        chk("nb1_run_num1", 64'(n1_1), 64'h58);
        chk("nb1_run_num2", 64'(n2_1), 64'hBB);
        chk("nb1_run_cin", 64'(ci1), 64'd0);
        step();
        chk("nb1_done_valid", 64'(ov1), 64'd1);
        chk("nb1_sum", 64'(os1), 64'h13);
        chk("nb1_cout", 64'(oc1), 64'd1);
        chk("nb1_done_in_ready", 64'(ir1), 64'd0);
        chk("nb1_done_num1", 64'(n1_1), 64'd0);
        step();
        chk("nb1_idle_valid", 64'(ov1), 64'd0);
        chk("nb1_idle_ready", 64'(ir1), 64'd1);

        // 4-byte carry ripple: 0xFFFFFFFF + 1
        a4 = 32'hFFFFFFFF; b4 = 32'h00000001; cin4 = 1'b0; iv4 = 1'b1; or4 = 1'b1;
        step();
        iv4 = 1'b0;
        chk("rip_c1_cin", 64'(ci4), 64'd0);
        chk("rip_c1_num1", 64'(n1_4), 64'hFF);
        chk("rip_c1_num2", 64'(n2_4), 64'h01);
        step();
        chk("rip_c2_cin", 64'(ci4), 64'd1);
        chk("rip_c2_num2", 64'(n2_4), 64'h00);
        step();
        chk("rip_c3_cin", 64'(ci4), 64'd1);
        step();
        chk("rip_c4_cin", 64'(ci4), 64'd1);
        chk("rip_c4_valid", 64'(ov4), 64'd0);
        step();
        chk("rip_valid", 64'(ov4), 64'd1);
        chk("rip_sum", 64'(os4), 64'h0);
        chk("rip_cout", 64'(oc4), 64'd1);
        step();
        chk("rip_idle_valid", 64'(ov4), 64'd0);

        // 4-byte with carry in, byte order check, then backpressure
        a4 = 32'h12345678; b4 = 32'h11111111; cin4 = 1'b1; iv4 = 1'b1; or4 = 1'b0;
        step();
        iv4 = 1'b0;
        chk("seq_num1_b0", 64'(n1_4), 64'h78);
        chk("seq_cin_b0", 64'(ci4), 64'd1);
        step();
        chk("seq_num1_b1", 64'(n1_4), 64'h56);
        step();
        chk("seq_num1_b2", 64'(n1_4), 64'h34);
        step();
        chk("seq_num1_b3", 64'(n1_4), 64'h12);
        step();
        chk("seq_valid", 64'(ov4), 64'd1);
        chk("seq_sum", 64'(os4), 64'h2345678A);
        chk("seq_cout", 64'(oc4), 64'd0);
        a4 = 32'h0F0F0F0F; b4 = 32'hF0F0F0F0; cin4 = 1'b1; iv4 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", 64'(ov4), 64'd1);
            chk("bp_sum", 64'(os4), 64'h2345678A);
            chk("bp_in_ready", 64'(ir4), 64'd0);
        end
        or4 = 1'b1;
        step();
        chk("bp_rel_valid", 64'(ov4), 64'd0);
        chk("bp_rel_ready", 64'(ir4), 64'd1);
        step();
        iv4 = 1'b0;
        chk("bp_new_num1", 64'(n1_4), 64'h0F);
        chk("bp_new_cin", 64'(ci4), 64'd1);
        step();
        step();
        step();
        step();
        chk("bp_new_valid", 64'(ov4), 64'd1);
        chk("bp_new_sum", 64'(os4), 64'h0);
        chk("bp_new_cout", 64'(oc4), 64'd1);
        step();

        // Reset during the second RUN cycle
        a4 = 32'h01010101; b4 = 32'h02020202; cin4 = 1'b0; iv4 = 1'b1;
        step();
        iv4 = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("mr_in_ready", 64'(ir4), 64'd1);
        chk("mr_valid", 64'(ov4), 64'd0);
        chk("mr_num1", 64'(n1_4), 64'd0);
        chk("mr_num2", 64'(n2_4), 64'd0);
        chk("mr_cin", 64'(ci4), 64'd0);
        chk("mr_sum", 64'(os4), 64'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("mr_no_pulse", 64'(ov4), 64'd0);
        end
        a1 = 8'h58; b1 = 8'hBB; cin1 = 1'b0; iv1 = 1'b1; or1 = 1'b1;
        step();
        iv1 = 1'b0;
        step();
        chk("mr_nb1_valid", 64'(ov1), 64'd1);
        chk("mr_nb1_sum", 64'(os1), 64'h13);
        chk("mr_nb1_cout", 64'(oc1), 64'd1);
        step();

        // Back-to-back with in_valid and out_ready held high
        or4 = 1'b1;
        iv4 = 1'b1;
        last_cyc = 0;
        for (int k = 0; k < 8; k++) begin
            a4 = ta[k]; b4 = tb[k]; cin4 = tc[k];
            ref_sum = {1'b0, ta[k]} + {1'b0, tb[k]} + {32'd0, tc[k]};
            waited = 0;
            do begin
                step();
                waited++;
            end while (ov4 !== 1'b1 && waited < 20);
            chk("b2b_valid", 64'(ov4), 64'd1);
            chk("b2b_sum", 64'(os4), 64'(ref_sum[31:0]));
            chk("b2b_cout", 64'(oc4), 64'(ref_sum[32]));
            if (k > 0) chk("b2b_period", 64'(cyc - last_cyc), 64'd6);
            last_cyc = cyc;
        end
        iv4 = 1'b0;
        step();
        chk("b2b_end_valid", 64'(ov4), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
